bram_arbiter_rv32: RTL
======================

Name: bram_arbiter_rv32

Overview:
- Two-requester round-robin arbiter in front of a single-port 32-bit BRAM block with byte-lane writes and 1-cycle read latency.
- Shares one BRAM between the CPU data port (m0) and a secondary master (m1, e.g. debug/DMA loader).
- Performs address-window checking and returns read data to the owning requester.
- Sits between the bus masters and the BRAM instance in the top-level.

Parameters:
- BaseAddress, 0, first byte address of the BRAM window (inclusive).
- EndAddress, 0, last byte address of the BRAM window (inclusive).
- data_width, 32, data bus width.
- address_width, 32, byte address width.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- m0_req  in  1  requester 0 access request; held until m0_gnt.
- m0_addr  in  address_width  requester 0 byte address.
- m0_wr  in  4  requester 0 byte-lane write enables; 0 = read.
- m0_din  in  data_width  requester 0 write data.
- m0_lock  in  1  requester 0 lock request (used only with BRAM_ARB_LOCK_EN).
- m0_gnt  out  1  requester 0 granted this cycle.
- m0_rvalid  out  1  requester 0 response valid (1 cycle after grant).
- m0_err  out  1  requester 0 access was out of window; qualified by m0_rvalid.
- m0_dout  out  data_width  requester 0 read data.
- m1_req, m1_addr, m1_wr, m1_din, m1_gnt, m1_rvalid, m1_err, m1_dout: identical roles for requester 1 (no lock input).
- mem_addr  out  address_width  BRAM byte offset (addr - BaseAddress).
- mem_wr  out  4  BRAM byte-lane write enables.
- mem_din  out  data_width  BRAM write data.
- mem_dout  in  data_width  BRAM read data, valid the cycle after the address.

Behaviour:
- Request rule: requester holds req/addr/wr/din stable until it sees gnt high at a clk edge. The transfer occurs on that edge.
- Grant generation (combinational, same cycle):
  - Only one requester active: that one wins.
  - Both active: winner = prio register.
  - Neither active: no grant.
- At most one gnt is high per cycle.
- mem_* are driven from the winner. With no winner: mem_addr=0, mem_wr=0, mem_din=0.
- Window check: in range when BaseAddress <= addr <= EndAddress.
  - In range: mem_addr = addr - BaseAddress; mem_wr = wr.
  - Out of range: still granted, mem_wr forced 0, mem_addr=0.
- prio register: 1 bit, reset 0 (m0 favoured). On any grant it is set to the index of the non-granted requester, so consecutive contention alternates m0,m1,m0,...
- Response pipeline (registered on the grant edge):
  - owner <= winner index; rv <= 1 if any grant, else 0; err_q <= out-of-range flag.
  - Next cycle: mN_rvalid = rv && owner==N; mN_err = rvalid && err_q.
  - mN_dout = mem_dout when mN_rvalid && !err_q, else 0.
- Writes also produce rvalid (write acknowledge); dout is don't-care-zero for writes.
- Throughput: one grant per cycle. Back-to-back grants are allowed, including grant and rvalid in the same cycle (pipelined).
- Reset values: prio=0, rv=0, owner=0, err_q=0. With no requests, all gnt/rvalid/err are 0 and all dout are 0.
- Reset asserted mid-transfer: any pending response is dropped (no rvalid after reset release). The requester must re-issue.
- Request dropped before grant: not permitted; behaviour is undefined and assertion-flagged in sim.

Optional Feature:
- Macro: BRAM_ARB_LOCK_EN.
- With the macro:
  - If m0 was the last granted requester and m0_lock is high, m0 keeps priority regardless of prio. m1 is not granted while m0_req && m0_lock stay high, enabling atomic read-modify-write.
  - Lock is released on the first cycle m0_lock is low.
  - A 4-bit lock counter forces one m1 grant opportunity after 15 consecutive locked m0 grants.
- Without the macro: m0_lock is ignored and pure round-robin applies.

Test Plan:
- BaseAddress=0x1000, EndAddress=0x1FFF; m0 writes 0xDEADBEEF with wr=4'hF to 0x1004, then reads 0x1004 -> mem_addr=0x004, m0_rvalid one cycle after each gnt, read m0_dout=0xDEADBEEF, m0_err=0.
- m0 and m1 both hold read requests for 4 cycles from reset -> gnt order m0,m1,m0,m1; each rvalid arrives on the matching port one cycle after its gnt.
- m1 writes wr=4'b0010 data 0x0000AB00 to 0x1008 holding 0x11223344 -> readback 0x1122AB44.
- m0 reads 0x2000 (out of window) -> m0_gnt=1, mem_wr=0, next cycle m0_rvalid=1, m0_err=1, m0_dout=0.
- Reset asserted the cycle after an m1 grant -> no m1_rvalid after release; prio=0, so simultaneous requests grant m0 first.
- BRAM_ARB_LOCK_EN defined, m0_lock=1 with continuous m0/m1 requests -> m0 granted 15 consecutive times, then m1 granted once; with the macro undefined -> strict alternation.

Source files
------------

// File: rtl/bram_arbiter_rv32_if.sv
// bram_arbiter_rv32_if: request/response bus between one bus master and the
// BRAM arbiter. The lock line only has meaning on requester 0; other users
// tie it low.
interface bram_arbiter_rv32_if #(
    parameter int unsigned data_width    = 32,
    parameter int unsigned address_width = 32
);
    logic                     req;
    logic [address_width-1:0] addr;
    logic [3:0]               wr;
    logic [data_width-1:0]    din;
    logic                     lock;
    logic                     gnt;
    logic                     rvalid;
    logic                     err;
    logic [data_width-1:0]    dout;

    // Bus master side: issues requests, receives grant and response.
    modport master (
        output req, addr, wr, din, lock,
        input  gnt, rvalid, err, dout
    );

    // Arbiter side: receives requests, returns grant and response.
    modport slave (
        input  req, addr, wr, din, lock,
        output gnt, rvalid, err, dout
    );
endinterface

// File: rtl/bram_arbiter_rv32.sv
// bram_arbiter_rv32: two-requester round-robin arbiter in front of a
// single-port 32-bit BRAM with byte-lane writes and 1-cycle read latency.
// Out-of-window accesses are granted but never reach the BRAM, and are
// answered with an error response.
// Optional feature: define BRAM_ARB_LOCK_EN to let requester 0 hold the BRAM
// across consecutive grants with its lock line (bounded to 15 grants).
module bram_arbiter_rv32 #(
    parameter int unsigned              data_width    = 32,
    parameter int unsigned              address_width = 32,
    parameter logic [address_width-1:0] BaseAddress   = '0,
    parameter logic [address_width-1:0] EndAddress    = '0
) (
    input  logic                     clk,
    input  logic                     reset,
    bram_arbiter_rv32_if.slave       m0,
    bram_arbiter_rv32_if.slave       m1,
    output logic [address_width-1:0] mem_addr,
    output logic [3:0]               mem_wr,
    output logic [data_width-1:0]    mem_din,
    input  logic [data_width-1:0]    mem_dout
);

    logic                     prio;       // requester favoured on contention
    logic                     rv;         // a response is due this cycle
    logic                     owner;      // requester that owns the response
    logic                     err_q;      // that response is an error
    logic                     lock_hold;  // requester 0 keeps the BRAM
    logic                     m0_win;
    logic                     m1_win;
    logic                     any_win;
    logic                     in_range;
    logic [address_width-1:0] sel_addr;
    logic [3:0]               sel_wr;
    logic [data_width-1:0]    sel_din;
    logic [address_width:0]   offset;     // extra MSB is the borrow: addr < base
    logic                     m0_rvalid;
    logic                     m1_rvalid;
    logic                     unused_lock;

`ifdef BRAM_ARB_LOCK_EN
    logic       last_m0;   // requester 0 received the most recent grant
    logic [3:0] lock_cnt;  // consecutive locked grants to requester 0

    assign lock_hold   = last_m0 && m0.lock && (lock_cnt != 4'hF);
    assign unused_lock = m1.lock;

    // Track the lock run so requester 1 gets a slot after 15 locked grants.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_m0  <= 1'b0;
            lock_cnt <= '0;
        end else if (m0_win) begin
            last_m0  <= 1'b1;
            if (!m0.lock)
                lock_cnt <= '0;
            else if (lock_cnt != 4'hF)
                lock_cnt <= lock_cnt + 4'd1;
        end else if (m1_win) begin
            last_m0  <= 1'b0;
            lock_cnt <= '0;
        end else if (!m0.lock) begin
            lock_cnt <= '0;
        end
    end
`else
    assign lock_hold   = 1'b0;
    assign unused_lock = m0.lock ^ m1.lock;
`endif

    // Pick the winner, check its address window and steer it onto the BRAM.
    // NOTE: every output of this block gets a default first, so no path
    // leaves a signal unassigned and no latch can be inferred.
    always_comb begin
        m0_win   = m0.req && (!m1.req || lock_hold || !prio);
        m1_win   = m1.req && !m0_win;
        any_win  = m0_win || m1_win;
        sel_addr = m1_win ? m1.addr : m0.addr;
        sel_wr   = m1_win ? m1.wr   : m0.wr;
        sel_din  = m1_win ? m1.din  : m0.din;
        offset   = {1'b0, sel_addr} - {1'b0, BaseAddress};
        in_range = !offset[address_width] && !(sel_addr > EndAddress);
        mem_addr = '0;
        mem_wr   = '0;
        mem_din  = '0;
        if (any_win) begin
            mem_din = sel_din;
            if (in_range) begin
                mem_addr = offset[address_width-1:0];
                mem_wr   = sel_wr;
            end
        end
    end

    // Register the response on the grant edge and rotate priority.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prio  <= 1'b0;
            rv    <= 1'b0;
            owner <= 1'b0;
            err_q <= 1'b0;
        end else begin
            rv    <= any_win;
            err_q <= any_win && !in_range;
            if (any_win) begin
                owner <= m1_win;
                prio  <= m0_win;
            end
        end
    end

    assign m0_rvalid = rv && !owner;
    assign m1_rvalid = rv && owner;

    assign m0.gnt    = m0_win;
    assign m0.rvalid = m0_rvalid;
    assign m0.err    = m0_rvalid && err_q;
    assign m0.dout   = (m0_rvalid && !err_q) ? mem_dout : '0;

    assign m1.gnt    = m1_win;
    assign m1.rvalid = m1_rvalid;
    assign m1.err    = m1_rvalid && err_q;
    assign m1.dout   = (m1_rvalid && !err_q) ? mem_dout : '0;

    // A request must stay up until it is granted.
    m0_req_held: assert property (@(posedge clk) disable iff (reset)
        (m0.req && !m0.gnt) |=> m0.req);
    m1_req_held: assert property (@(posedge clk) disable iff (reset)
        (m1.req && !m1.gnt) |=> m1.req);
    one_grant: assert property (@(posedge clk) disable iff (reset)
        !(m0.gnt && m1.gnt));

endmodule
